// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, IF/ID register, skid buffer, link register
module fetch_unit #(
    parameter int              AW     = 8,
    parameter int              IW     = 16,
    parameter logic [AW-1:0]   RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    input  logic [1:0]    pc_sec,
    input  logic [AW-1:0] br_target,
    input  logic          lr_we,
    input  logic          stall,
    output logic [IW-1:0] if_id_ins,
    output logic [AW-1:0] if_id_pc,
    output logic          if_id_valid,
    output logic [AW-1:0] lr_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [IW-1:0] ins_q, ins_n, skid_ins, skid_ins_n;
    logic [AW-1:0] ipc_q, ipc_n, skid_pc, skid_pc_n, lr_q, lr_n;
    logic          valid_q, valid_n, skid_valid, skid_valid_n;
    logic          redirect;

    // pc_sec=10 is deliberately treated as sequential, so only bit 0 selects a redirect
    assign redirect = pc_sec[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RST_PC;
            ins_q      <= '0;
            ipc_q      <= '0;
            valid_q    <= 1'b0;
            skid_ins   <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
            lr_q       <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ins_q      <= ins_n;
            ipc_q      <= ipc_n;
            valid_q    <= valid_n;
            skid_ins   <= skid_ins_n;
            skid_pc    <= skid_pc_n;
            skid_valid <= skid_valid_n;
            lr_q       <= lr_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        ins_n        = ins_q;
        ipc_n        = ipc_q;
        valid_n      = valid_q;
        skid_ins_n   = skid_ins;
        skid_pc_n    = skid_pc;
        skid_valid_n = skid_valid;
        lr_n         = lr_q;

        if (redirect) begin
            pc_n         = pc_sec[1] ? lr_q : br_target;
            valid_n      = 1'b0;
            skid_valid_n = 1'b0;
            state_n      = S_REQ;
        end else begin
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        if (!stall || !valid_q) begin
                            ins_n   = imem_data;
                            ipc_n   = pc;
                            valid_n = 1'b1;
                        end else begin
                            skid_ins_n   = imem_data;
                            skid_pc_n    = pc;
                            skid_valid_n = 1'b1;
                            state_n      = S_HOLD;
                        end
                        pc_n = pc + AW'(1);
                    end else if (!stall) begin
                        valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ins_n        = skid_ins;
                        ipc_n        = skid_pc;
                        valid_n      = 1'b1;
                        skid_valid_n = 1'b0;
                        state_n      = S_REQ;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Link capture sees the pre-edge IF/ID, so a same-cycle return still uses the old lr
        if (lr_we && valid_q)
            lr_n = ipc_q + AW'(1);
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign if_id_ins   = ins_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;
    assign lr_out      = lr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [1:0]  pc_sec;
    logic [7:0]  br_target;
    logic        lr_we;
    logic        stall;
    logic [15:0] if_id_ins;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [7:0]  lr_out;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.AW(8), .IW(16), .RST_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .pc_sec(pc_sec), .br_target(br_target), .lr_we(lr_we), .stall(stall),
        .if_id_ins(if_id_ins), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .lr_out(lr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  pc;
    } entry_t;

    // Pipeline contents as a queue: head is what decode sees, a second entry is the parked fetch
    entry_t     q[$];
    entry_t     shown;
    logic [7:0] m_pc;
    logic [7:0] m_lr;
    bit         m_bubble;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    task automatic model_reset();
        q.delete();
        shown    = '{16'h0000, 8'h00};
        m_pc     = 8'h00;
        m_lr     = 8'h00;
        m_bubble = 1'b1;
    endtask

    task automatic cycle(input bit r, input bit ack, input bit stl, input logic [1:0] sec,
                         input logic [7:0] tgt, input bit lw);
        bit         req, had_valid;
        logic [7:0] head_pc;
        rst       = r;
        imem_ack  = ack;
        imem_data = mem_word(m_pc);
        stall     = stl;
        pc_sec    = sec;
        br_target = tgt;
        lr_we     = lw;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            req       = !m_bubble && (q.size() < 2);
            had_valid = (q.size() > 0);
            head_pc   = shown.pc;
            if (sec == 2'b01 || sec == 2'b11) begin
                q.delete();
                m_pc     = (sec == 2'b01) ? tgt : m_lr;
                m_bubble = 1'b0;
            end else if (m_bubble) begin
                m_bubble = 1'b0;
            end else begin
                if (!stl && q.size() > 0) void'(q.pop_front());
                if (req && ack) begin
                    q.push_back('{mem_word(m_pc), m_pc});
                    m_pc = m_pc + 8'd1;
                end
            end
            if (lw && had_valid) m_lr = head_pc + 8'd1;
            if (q.size() > 0) shown = q[0];
        end
        #1;
        check("imem_req",    32'(imem_req),    32'(!m_bubble && q.size() < 2));
        check("imem_addr",   32'(imem_addr),   32'(m_pc));
        check("if_id_valid", 32'(if_id_valid), 32'(q.size() > 0));
        check("if_id_ins",   32'(if_id_ins),   32'(shown.ins));
        check("if_id_pc",    32'(if_id_pc),    32'(shown.pc));
        check("lr_out",      32'(lr_out),      32'(m_lr));
    endtask

    initial begin
        model_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_data = '0; stall = 1'b0;
        pc_sec = 2'b00; br_target = '0; lr_we = 1'b0;

        // reset and sequential fetch, ack every cycle
        cycle(1, 0, 0, 2'b00, 8'h00, 0);
        cycle(1, 1, 0, 2'b00, 8'h00, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // three-cycle ack latency
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 2'b00, 8'h00, 0);
            cycle(0, 0, 0, 2'b00, 8'h00, 0);
            cycle(0, 1, 0, 2'b00, 8'h00, 0);
        end

        // stall with a fetch parked in the skid, then release
        cycle(0, 1, 1, 2'b00, 8'h00, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 2'b00, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // redirect in an ack cycle discards the data
        cycle(0, 1, 0, 2'b01, 8'h40, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // call from 12 to 30, then return to 13, then lr_we with return in the same cycle
        cycle(0, 0, 0, 2'b01, 8'h12, 0);
        cycle(0, 1, 0, 2'b00, 8'h00, 0);
        cycle(0, 0, 1, 2'b01, 8'h30, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);
        cycle(0, 0, 0, 2'b11, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);
        cycle(0, 1, 0, 2'b11, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // PC wrap FE -> FF -> 00, and sustained redirect
        cycle(0, 1, 0, 2'b01, 8'hFE, 0);
        cycle(0, 1, 0, 2'b01, 8'hFE, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // reset during REQ with a pending ack
        cycle(1, 1, 0, 2'b00, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 8'h00, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int p;
            logic [1:0] sec;
            p = $urandom_range(0, 99);
            sec = (p < 5) ? 2'b01 : (p < 8) ? 2'b11 : (p < 12) ? 2'b10 : 2'b00;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 35, sec, 8'($urandom), $urandom_range(0, 99) < 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 8-bit CPU. Owns the program counter and the instruction-memory request handshake.
- Registers fetched instructions into the IF/ID pipeline register and holds the link register.
- Consumes the branch controller's pc select and link-write outputs from decode, and feeds decode.
- Supports stall from hazard logic and flush on redirect.

Parameters:
AW, 8, PC/address width
IW, 16, instruction width
RST_PC, 8'h00, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  AW  fetch address, equals current PC
imem_ack  in  1  imem_data valid for imem_addr this cycle; meaningful only while imem_req=1
imem_data  in  IW  fetched instruction
pc_sec  in  2  from branch control: 00 sequential, 01 branch target, 11 return via link register, 10 treated as 00
br_target  in  AW  branch target address (used when pc_sec=01)
lr_we  in  1  write link register (BR.SUB)
stall  in  1  decode cannot accept; hold IF/ID
if_id_ins  out  IW  registered instruction to decode
if_id_pc  out  AW  PC of if_id_ins
if_id_valid  out  1  IF/ID holds a live instruction
lr_out  out  AW  link register value

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high; one clock domain.
- Reset values:
  - pc=RST_PC, state=IDLE, imem_req=0, imem_addr=RST_PC.
  - if_id_valid=0, if_id_ins=0, if_id_pc=0, lr_out=0, skid empty.
- rst mid-transaction drops imem_req the next cycle; any ack in the rst cycle is ignored.
- imem_addr is always pc (registered, no combinational path from inputs).
- Memory is abort-tolerant: imem_addr may change while imem_req=1. An ack always refers to the imem_addr of the same cycle.
- FSM states:
  - IDLE: imem_req=0. Next cycle goes to REQ unconditionally; gives one bubble after reset.
  - REQ: imem_req=1. Waits any number of cycles for imem_ack.
  - HOLD: imem_req=0. A fetched instruction waits in the 1-entry skid buffer because IF/ID was stalled.
- Accepted ack: state=REQ, imem_ack=1, no redirect.
  - If stall=0 or if_id_valid=0: IF/ID <= {imem_data, pc}, valid <= 1, stay in REQ.
  - If stall=1 and if_id_valid=1: skid <= {imem_data, pc}, go to HOLD.
  - Either way pc <= pc+1, modulo 2^AW (8'hFF -> 8'h00, no flag).
- REQ without ack: if stall=0, if_id_valid <= 0 (instruction consumed, bubble). If stall=1, IF/ID holds.
- HOLD: when stall=0, IF/ID <= skid, valid <= 1, skid emptied, go to REQ. While stall=1, stay in HOLD.
- Redirect (pc_sec=01 or 11) has highest priority, above stall, ack and HOLD:
  - pc <= br_target (01) or current lr_out (11).
  - if_id_valid <= 0; skid cleared; state <= REQ.
  - Any imem_ack in the redirect cycle is discarded and pc is not incremented.
  - Sustained redirect cycles each reload pc; no fetch is accepted until pc_sec returns to 00/10.
- Link register:
  - When lr_we=1 and if_id_valid=1: lr_out <= if_id_pc+1 (mod 2^AW).
  - When lr_we=1 and if_id_valid=0: ignored.
  - lr_we together with pc_sec=11 in the same cycle: the target uses the old lr_out, and lr_out updates at the edge.
- Throughput: with ack every cycle and no stall, one instruction per cycle. Latency: ack cycle -> if_id_valid on the next edge.
- if_id_ins/if_id_pc are stable whenever if_id_valid=1 and stall=1.

Test Plan:
- Reset then sequential fetch, imem_data=16'h1000+addr, ack every cycle: imem_req rises 1 cycle after reset release; if_id_pc=00,01,02,... on consecutive cycles; if_id_ins=16'h1000,16'h1001,...
- Ack latency 3 cycles per fetch: imem_addr held 3 cycles; if_id_valid=1 for 1 cycle then 0 for 2 (bubbles); pc advances by exactly 1 per ack.
- Stall 4 cycles while IF/ID holds pc 05 and ack arrives for 06:
  - IF/ID stays 05 and state enters HOLD with imem_req=0.
  - On stall release, IF/ID=06 next cycle, then fetch of 07 begins.
- Redirect pc_sec=01, br_target=8'h40, in the same cycle as ack for 08: data discarded; if_id_valid=0; next imem_addr=40; next valid instruction has if_id_pc=40.
- BR.SUB then return:
  - lr_we=1 with if_id_pc=8'h12 and pc_sec=01 target 30 gives lr_out=13 and fetch from 30.
  - Later pc_sec=11 gives fetch from 13.
  - Also check lr_we with pc_sec=11 in the same cycle: target is the old lr_out.
- Wrap and mid-operation reset:
  - Sequential fetch from FE: if_id_pc=FE, FF, 00.
  - Assert rst during REQ with pending ack: all outputs return to reset values next edge; ack ignored.
